// File: rtl/delay_tap_scheduler.sv
// delay_tap_scheduler: sequences a single-port delay-line BRAM so that each
// audio sample gets one write followed by NUM_TAPS delayed reads, then mixes
// the dry sample with the gain-weighted taps into a saturated 16-bit output.
module delay_tap_scheduler #(
  parameter int NUM_TAPS     = 4,
  parameter int RAM_DEPTH    = 48000,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      enable_in,
  input  logic                      audio_valid_in,
  input  logic [15:0]               audio_in,
  input  logic [16*NUM_TAPS-1:0]    tap_delay_in,
  input  logic [8*NUM_TAPS-1:0]     tap_gain_in,
  output logic [15:0]               ram_addr_out,
  output logic                      ram_we_out,
  output logic [15:0]               ram_din_out,
  input  logic [15:0]               ram_dout_in,
  output logic [15:0]               mix_out,
  output logic                      mix_valid_out,
  output logic                      busy_out,
  output logic                      overrun_out
);

  localparam int ACC_W  = 17 + $clog2(NUM_TAPS + 1);
  localparam int TW     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int TSLOTS = 1 << TW;
  localparam int DW     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [16:0]   DEPTH      = 17'(RAM_DEPTH);
  localparam logic [16:0]   DMAX       = 17'(RAM_DEPTH - 1);
  localparam logic [15:0]   WP_LAST    = 16'(RAM_DEPTH - 1);
  localparam logic [TW-1:0] LAST_TAP   = TW'(NUM_TAPS - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(READ_LATENCY - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t state, next_state;

  logic [15:0]              wp;
  logic [15:0]              wr_addr;
  logic [15:0]              sample;
  logic [15:0]              delay_lat [TSLOTS];
  logic [7:0]               gain_lat  [TSLOTS];
  logic [TW-1:0]            tap_cnt;
  logic [DW-1:0]            drain_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [READ_LATENCY-1:0]  pipe_valid;
  logic [TW-1:0]            pipe_idx [READ_LATENCY];

  // Tap ports padded out to a power-of-two slot count so the latch arrays
  // can be indexed by a full-width tap counter.
  logic [16*TSLOTS-1:0]     delay_pad;
  logic [8*TSLOTS-1:0]      gain_pad;
  assign delay_pad = (16*TSLOTS)'(tap_delay_in);
  assign gain_pad  = (8*TSLOTS)'(tap_gain_in);

  logic [TW-1:0]            ret_idx;
  logic [7:0]               ret_gain;
  logic signed [24:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic [TW-1:0]            next_tap;
  logic [15:0]              rd_addr;

  // Circular read address: delay clamped to depth-1, wraps below zero.
  function automatic logic [15:0] tap_addr(input logic [15:0] delay, input logic [15:0] base);
    logic [16:0] d;
    logic [16:0] b;
    logic [16:0] r;
    d = (17'(delay) > DMAX) ? DMAX : 17'(delay);
    b = 17'(base);
    if (d <= b) r = b - d;
    else        r = b + DEPTH - d;
    return r[15:0];
  endfunction

  // Clamp the wide accumulator into the signed 16-bit output range.
  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return 16'h7FFF;
    else if (v < SAT_MIN) return 16'h8000;
    else                  return v[15:0];
  endfunction

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (audio_valid_in && enable_in) next_state = WRITE;
        else                             next_state = IDLE;
      end
      WRITE:  next_state = READ;
      READ: begin
        if (tap_cnt == LAST_TAP) next_state = DRAIN;
        else                     next_state = READ;
      end
      DRAIN: begin
        if (drain_cnt == LAST_DRAIN) next_state = OUTPUT;
        else                         next_state = DRAIN;
      end
      OUTPUT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Returned-word weighting, accumulator update and next read address.
  always_comb begin
    ret_idx  = pipe_idx[READ_LATENCY-1];
    ret_gain = gain_lat[ret_idx];
    prod     = $signed(ram_dout_in) * $signed({1'b0, ret_gain});
    prod_ext = ACC_W'(prod >>> 8);
    if (pipe_valid[READ_LATENCY-1]) acc_next = acc + prod_ext;
    else                            acc_next = acc;
    if (state == WRITE)             next_tap = {TW{1'b0}};
    else if (tap_cnt == LAST_TAP)   next_tap = tap_cnt;
    else                            next_tap = tap_cnt + TW'(1);
    rd_addr = tap_addr(delay_lat[next_tap], wr_addr);
  end

  // Datapath, read-tracking pipeline and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wp            <= 16'd0;
      wr_addr       <= 16'd0;
      sample        <= 16'd0;
      tap_cnt       <= {TW{1'b0}};
      drain_cnt     <= {DW{1'b0}};
      acc           <= {ACC_W{1'b0}};
      pipe_valid    <= {READ_LATENCY{1'b0}};
      ram_addr_out  <= 16'd0;
      ram_we_out    <= 1'b0;
      ram_din_out   <= 16'd0;
      mix_out       <= 16'd0;
      mix_valid_out <= 1'b0;
      busy_out      <= 1'b0;
      overrun_out   <= 1'b0;
      for (int i = 0; i < TSLOTS; i++) begin
        delay_lat[i] <= 16'd0;
        gain_lat[i]  <= 8'd0;
      end
      for (int i = 0; i < READ_LATENCY; i++) pipe_idx[i] <= {TW{1'b0}};
    end else begin
      mix_valid_out <= 1'b0;
      overrun_out   <= audio_valid_in && (state != IDLE);
      busy_out      <= (next_state != IDLE);

      // A read is issued in every READ cycle; its data returns READ_LATENCY later.
      pipe_valid[0] <= (state == READ);
      pipe_idx[0]   <= tap_cnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
      end

      case (state)
        IDLE: begin
          if (audio_valid_in && enable_in) begin
            sample       <= audio_in;
            wr_addr      <= wp;
            ram_addr_out <= wp;
            ram_we_out   <= 1'b1;
            ram_din_out  <= audio_in;
            for (int i = 0; i < TSLOTS; i++) begin
              delay_lat[i] <= delay_pad[16*i +: 16];
              gain_lat[i]  <= gain_pad[8*i +: 8];
            end
          end else if (audio_valid_in) begin
            mix_out       <= audio_in;
            mix_valid_out <= 1'b1;
          end else begin
            ram_we_out <= 1'b0;
          end
        end
        WRITE: begin
          ram_we_out   <= 1'b0;
          ram_addr_out <= rd_addr;
          acc          <= ACC_W'($signed(sample));
          tap_cnt      <= {TW{1'b0}};
          drain_cnt    <= {DW{1'b0}};
          wp           <= (wp == WP_LAST) ? 16'd0 : wp + 16'd1;
        end
        READ: begin
          acc <= acc_next;
          if (tap_cnt != LAST_TAP) begin
            ram_addr_out <= rd_addr;
            tap_cnt      <= tap_cnt + TW'(1);
          end else begin
            drain_cnt <= {DW{1'b0}};
          end
        end
        DRAIN: begin
          acc <= acc_next;
          if (drain_cnt == LAST_DRAIN) begin
            mix_out       <= sat16(acc_next);
            mix_valid_out <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        OUTPUT: begin
          ram_we_out <= 1'b0;
        end
        default: begin
          ram_we_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Scoreboard bench for delay_tap_scheduler with a small BRAM model
// (RAM_DEPTH=16 so that pointer wrap-around is reachable quickly).
module tb_delay_tap_scheduler;

  localparam int NT    = 4;
  localparam int DEPTH = 16;
  localparam int RL    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        audio_valid;
  logic [15:0] audio;
  logic [63:0] tap_delay;
  logic [31:0] tap_gain;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [15:0] mix;
  logic        mix_valid;
  logic        busy;
  logic        overrun;
  logic        clear_mem;

  always #5 clk = ~clk;

  delay_tap_scheduler #(.NUM_TAPS(NT), .RAM_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .audio_valid_in(audio_valid),
    .audio_in(audio), .tap_delay_in(tap_delay), .tap_gain_in(tap_gain),
    .ram_addr_out(ram_addr), .ram_we_out(ram_we), .ram_din_out(ram_din),
    .ram_dout_in(ram_dout), .mix_out(mix), .mix_valid_out(mix_valid),
    .busy_out(busy), .overrun_out(overrun)
  );

  // BRAM model, two-cycle read latency
  logic [15:0] mem [DEPTH];
  logic [15:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'd0;
    end else if (ram_we) begin
      mem[ram_addr[3:0]] <= ram_din;
    end
    rd_pipe[0] <= mem[ram_addr[3:0]];
    rd_pipe[1] <= rd_pipe[0];
  end
  assign ram_dout = rd_pipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_val_q[$];
  int exp_cyc_q[$];
  int exp_wp = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every mix strobe is matched against the oldest expectation
  always @(negedge clk) begin
    if (mix_valid) begin
      if (exp_val_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mix_unexpected: got strobe with %0d at cycle %0d, required none",
                 $signed(mix), cyc);
      end else begin
        check("mix_value", int'($signed(mix)), exp_val_q.pop_front());
        check("mix_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // One sample: strobe in cycle 0, optional second strobe, per-cycle port checks
  task automatic run_sample(input int s, input logic en, input int exp_mix, input int second);
    int t0;
    int wr;
    int d;
    wr = exp_wp;
    @(posedge clk); #1;
    audio       = 16'(s);
    enable      = en;
    audio_valid = 1'b1;
    t0          = cyc;
    exp_val_q.push_back(exp_mix);
    exp_cyc_q.push_back(t0 + (en ? 8 : 1));
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      audio_valid = (c == second);
      if (en && c == 1) begin
        check("write_we",   int'(ram_we), 1);
        check("write_addr", int'(ram_addr), wr);
        check("write_din",  int'($signed(ram_din)), s);
      end
      if (en && c >= 2 && c <= 5) begin
        d = int'(tap_delay[16*(c-2) +: 16]);
        check("read_addr", int'(ram_addr), (wr - d + DEPTH) % DEPTH);
        check("read_we",   int'(ram_we), 0);
      end
      if (en) check("busy", int'(busy), (c <= 8) ? 1 : 0);
      else    check("pass_we", int'(ram_we), 0);
      check("overrun", int'(overrun), (second >= 0 && c == second + 1) ? 1 : 0);
    end
    audio_valid = 1'b0;
    if (en) exp_wp = (wr + 1) % DEPTH;
  endtask

  initial begin
    int e;
    rst = 1'b1; enable = 1'b0; audio_valid = 1'b0; audio = 16'd0;
    tap_delay = 64'd0; tap_gain = 32'd0; clear_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; clear_mem = 1'b0;
    check("rst_mix",       int'(mix), 0);
    check("rst_mix_valid", int'(mix_valid), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_overrun",   int'(overrun), 0);
    check("rst_we",        int'(ram_we), 0);
    check("rst_addr",      int'(ram_addr), 0);
    check("rst_din",       int'(ram_din), 0);

    // Impulse through tap0 (delay 3, gain 0.5)
    tap_delay = {16'd0, 16'd0, 16'd0, 16'd3};
    tap_gain  = {8'd0, 8'd0, 8'd0, 8'd128};
    run_sample(16000, 1'b1, 16000, -1);
    run_sample(0, 1'b1, 0, -1);
    run_sample(0, 1'b1, 0, -1);
    run_sample(0, 1'b1, 8000, -1);
    run_sample(0, 1'b1, 0, -1);

    // Saturation: two full-gain zero-delay taps
    tap_delay = 64'd0;
    tap_gain  = {8'd0, 8'd0, 8'd255, 8'd255};
    run_sample(30000, 1'b1, 32767, -1);
    run_sample(-30000, 1'b1, -32768, -1);

    // Overrun in a READ cycle and exactly in the OUTPUT cycle
    tap_gain = 32'd0;
    run_sample(100, 1'b1, 100, 4);
    run_sample(200, 1'b1, 200, 8);
    run_sample(300, 1'b1, 300, -1);

    // Reset in cycle 3 of a sample
    @(posedge clk); #1;
    audio = 16'd500; enable = 1'b1; audio_valid = 1'b1;
    @(posedge clk); #1; audio_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1; clear_mem = 1'b1;
    @(posedge clk); #1;
    check("midrst_mix",       int'(mix), 0);
    check("midrst_mix_valid", int'(mix_valid), 0);
    check("midrst_busy",      int'(busy), 0);
    check("midrst_overrun",   int'(overrun), 0);
    check("midrst_we",        int'(ram_we), 0);
    check("midrst_addr",      int'(ram_addr), 0);
    check("midrst_din",       int'(ram_din), 0);
    rst = 1'b0; clear_mem = 1'b0;
    exp_wp = 0;
    repeat (10) @(posedge clk);

    // Wrap-around: sample k at address k-1 mod 16, tap0 looks back 5 samples
    tap_delay = {16'd0, 16'd0, 16'd0, 16'd5};
    tap_gain  = {8'd0, 8'd0, 8'd0, 8'd255};
    for (int k = 1; k <= 20; k++) begin
      e = k + ((k > 5) ? ((k - 5) * 255) / 256 : 0);
      run_sample(k, 1'b1, e, -1);
    end

    // Passthrough, then confirm the pointer did not move (reads sample 16)
    run_sample(-1234, 1'b0, -1234, -1);
    run_sample(7, 1'b1, 22, -1);

    repeat (5) @(posedge clk);
    #1;
    check("pending_mix", exp_val_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
